// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter with valid/ready write port and free-space report.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_data_in,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  output logic [TX_FIFO_DEPTH:0]   o_tx_free,
  output logic                     o_tx,
  output logic                     o_busy
);
  localparam int N  = 1 << TX_FIFO_DEPTH;
  localparam int PW = TX_FIFO_DEPTH;
  localparam int AW = TX_FIFO_DEPTH + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem_q [N];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          push, pop, empty, tick;

  assign empty      = count_q == '0;
  assign o_wr_ready = count_q != AW'(N);
  assign o_tx_free  = AW'(N) - count_q;
  assign o_tx       = tx_q;
  assign o_busy     = (state_q != IDLE) || !empty;
  assign push       = i_wr_valid && o_wr_ready;
  assign tick       = cnt_q == CW'(CLKS_PER_BIT - 1);

  assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
  assign count_d  = count_q + AW'(push) - AW'(pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
        tx_d    = bit_q == 3'd7 ? 1'b1 : shift_q[1];
      end
      STOP: if (tick) begin
        // Chain straight into the next start bit so queued frames have no idle gap.
        pop     = !empty;
        shift_d = empty ? shift_q : mem_q[rd_ptr_q];
        state_d = empty ? IDLE : START;
        tx_d    = empty;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data_in;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: queue-level model, line receiver and directed vectors for uart_tx_fifo.
module tb_uart_tx_fifo;
  localparam int C = 4;
  localparam int F = 10 * C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       wr_valid, wr_ready, tx, busy;
  logic [4:0] tx_free;
  int         n_vec = 0;
  int         n_bad = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .TX_FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_data_in(din), .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready), .o_tx_free(tx_free), .o_tx(tx), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: bytes waiting in the FIFO, and position within the frame on the line.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  logic       m_act;
  int         m_t, m_sz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_act <= 1'b0;
      m_t   <= 0;
    end else begin
      m_sz = m_q.size();
      if (m_sz > 0 && (!m_act || m_t == F - 1)) begin
        m_cur <= m_q.pop_front();
        m_act <= 1'b1;
        m_t   <= 0;
      end else if (m_act) begin
        m_act <= m_t != F - 1;
        m_t   <= m_t + 1;
      end
      if (wr_valid && m_sz < 16) m_q.push_back(din);
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_act) return 1'b1;
    k = m_t / C;
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : m_cur[3'(k - 1)];
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("m_tx", tx, exp_tx());
      chk("m_free", tx_free, 32'(16 - m_q.size()));
      chk("m_ready", wr_ready, m_q.size() < 16);
      chk("m_busy", busy, m_act || m_q.size() > 0);
    end
  end

  // Independent line receiver: mid-bit sampling, aborted by reset.
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh;
  logic       rx_on;
  int         rx_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_on <= 1'b0;
      rx_c  <= 0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on <= 1'b1;
        rx_c  <= 0;
      end
    end else begin
      rx_c <= rx_c + 1;
      for (int k = 0; k < 8; k++)
        if (rx_c == (k + 1) * C + C / 2 - 1) rx_sh[3'(k)] <= tx;
      if (rx_c == 9 * C + C / 2 - 1) begin
        rx_on <= 1'b0;
        rx_q.push_back(rx_sh);
        chk("stop_bit", tx, 1);
      end
    end
  end

  task automatic expect_frames(input logic [7:0] a, input logic [7:0] b, input int n);
    logic [19:0] f;
    f = {1'b1, b, 1'b0, 1'b1, a, 1'b0};
    for (int i = 0; i < n * F; i++) begin
      chk("line", tx, f[5'(i / C)]);
      if (i == n * F - 1) chk("busy_last", busy, 1);
      @(negedge clk);
    end
    chk("busy_fall", busy, 0);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_bounded", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b);
    int n = 0;
    wr_valid = 1'b0;
    while (!wr_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wr_wait_bounded", 32'(n >= 500), 0);
    din = b;
    wr_valid = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0] exp_q[$];

  initial begin
    rst_n = 1'b1; wr_valid = 1'b0; din = '0;
    #2 rst_n = 1'b0; wr_valid = 1'b1; din = 8'h77;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", wr_ready, 1);
    chk("rst_free", tx_free, 16);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1; wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_free", tx_free, 16);
    chk("post_rst_busy", busy, 0);

    rx_q.delete();
    din = 8'hA5; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("a5_free_push", tx_free, 15);
    chk("a5_tx_before", tx, 1);
    @(negedge clk);
    chk("a5_free_pop", tx_free, 16);
    expect_frames(8'hA5, 8'h00, 1);
    chk("a5_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("a5_rx", rx_q[0], 8'hA5);

    rx_q.delete();
    for (int b = 0; b < 17; b++) begin
      din = 8'(b);
      wr_valid = 1'b1;
      @(negedge clk);
    end
    chk("fill_free", tx_free, 0);
    chk("fill_ready", wr_ready, 0);
    din = 8'h11;
    repeat (5) @(negedge clk);
    chk("full_free", tx_free, 0);
    chk("full_ready", wr_ready, 0);
    wr_valid = 1'b0;
    wait_idle(2000);
    chk("fill_rx_n", rx_q.size(), 17);
    for (int i = 0; i < rx_q.size() && i < 17; i++) chk("fill_rx", rx_q[i], 32'(i));

    rx_q.delete();
    din = 8'h55; wr_valid = 1'b1;
    @(negedge clk);
    din = 8'hAA;
    @(negedge clk);
    wr_valid = 1'b0;
    expect_frames(8'h55, 8'hAA, 2);
    chk("b2b_rx_n", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_rx0", rx_q[0], 8'h55);
      chk("b2b_rx1", rx_q[1], 8'hAA);
    end

    din = 8'h0F; wr_valid = 1'b1;
    @(negedge clk); din = 8'h01;
    @(negedge clk); din = 8'h02;
    @(negedge clk); din = 8'h03;
    @(negedge clk); wr_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_q_free", tx_free, 13);
    chk("mid_bit3", tx, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_free", tx_free, 16);
    chk("mid_rst_ready", wr_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    repeat (100) @(negedge clk);
    chk("mid_rx_none", rx_q.size(), 0);
    chk("mid_busy", busy, 0);

    din = 8'h3C; wr_valid = 1'b1;
    @(negedge clk); wr_valid = 1'b0;
    @(negedge clk);
    chk("start_low", tx, 0);
    #2 rst_n = 1'b0;
    #1 chk("start_rst_tx", tx, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("start_rx_none", rx_q.size(), 0);

    rx_q.delete();
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 5; j++) begin
        wr(8'(8'h40 + 5 * k + j));
        exp_q.push_back(8'(8'h40 + 5 * k + j));
      end
      wr_valid = 1'b0;
      repeat (100) @(negedge clk);
    end
    wait_idle(3000);
    chk("wrap_rx_n", rx_q.size(), 35);
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) chk("wrap_rx", rx_q[i], exp_q[i]);
    chk("wrap_first", exp_q[0], 8'h40);
    chk("wrap_last", rx_q.size() > 0 ? rx_q[rx_q.size() - 1] : 8'h00, 8'h62);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter that sits directly downstream of the MMIO decode at address 0xFFFF. It accepts bytes over a valid/ready write port into a power-of-two FIFO and reports free FIFO space for MMIO reads. It serializes each byte onto the TX line as 8N1, LSB first. It is the transmit half of the UART block instantiated at top level.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
TX_FIFO_DEPTH, 4, log2 of FIFO entry count (16 entries by default).

Ports:
i_clk  input  1  system clock; all state changes on rising edge.
i_rst  input  1  reset, asynchronous, active-low.
i_data_in  input  8  byte to transmit.
i_wr_valid  input  1  write request.
o_wr_ready  output  1  FIFO can accept a byte this cycle.
o_tx_free  output  TX_FIFO_DEPTH+1  free FIFO entries (0 .. 2^TX_FIFO_DEPTH).
o_tx  output  1  serial line; idle high.
o_busy  output  1  serializer is mid-frame, or the FIFO is non-empty.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - FIFO pointers and count cleared.
  - FSM forced to IDLE; bit and cycle counters cleared.
  - Outputs: o_tx=1, o_busy=0, o_wr_ready=1, o_tx_free=2^TX_FIFO_DEPTH.
  - A frame in progress is abandoned and the line returns high immediately.
  - Exit from reset is clean on the first rising edge with i_rst=1.
- Write handshake:
  - A byte is accepted on a rising edge where i_wr_valid && o_wr_ready.
  - o_wr_ready = !full. It is combinational from registered FIFO state only and never depends on i_wr_valid, because the MMIO decode feeds it back combinationally.
  - i_data_in is ignored when i_wr_valid=0.
- FIFO:
  - Storage is 2^TX_FIFO_DEPTH x 8.
  - Read and write pointers are TX_FIFO_DEPTH bits wide and wrap modulo depth.
  - Count is TX_FIFO_DEPTH+1 bits wide.
  - o_tx_free = 2^TX_FIFO_DEPTH - count, registered-state-derived. The byte held in the shift register is not counted.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - When full, o_wr_ready=0. A pop in the same cycle does not allow a push; the push is accepted on the following cycle.
- Serializer FSM states: IDLE, START, DATA, STOP. o_tx is driven from a register.
  - IDLE: o_tx=1. If the FIFO is non-empty: pop the head into an 8-bit shift register, clear the cycle counter, go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit 7, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - if the FIFO is non-empty, pop and go directly to START (no idle cycle between frames);
    - otherwise go to IDLE.
- Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE drives o_tx low from edge N+1. A frame is exactly 10*CLKS_PER_BIT cycles.
- Cycle counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1; the state/bit advances when count == CLKS_PER_BIT-1.
- o_busy = (state != IDLE) || (count != 0).

Test Plan:
- Reset values: hold i_rst=0 with i_wr_valid=1 -> o_tx=1, o_wr_ready=1, o_tx_free=16, o_busy=0, and nothing is written.
- Single byte (CLKS_PER_BIT=4): write 0xA5 at edge N -> o_tx low for edges N+1..N+4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. o_busy falls 40 cycles after N+1; o_tx_free returns to 16 at N+1.
- Fill: write 17 consecutive bytes 0x00..0x10 with the serializer stalled by large CLKS_PER_BIT:
  - first byte popped at N+1; bytes 0x01..0x10 fill the FIFO;
  - o_tx_free reaches 0 and o_wr_ready=0;
  - an extra write of 0x11 is not accepted and is never transmitted.
- Back-to-back: write 0x55 then 0xAA on consecutive cycles -> the STOP bit of 0x55 is followed immediately by the START bit of 0xAA with zero idle cycles. The total high time between frames is exactly CLKS_PER_BIT.
- Reset mid-frame: assert i_rst=0 during DATA bit 3 of 0x0F with 3 bytes queued:
  - o_tx goes to 1 asynchronously, o_tx_free=16;
  - after release, o_tx stays high and no queued byte is sent.
- Wrap-around: push and pop more than 2*16 bytes in bursts of 5 -> the transmitted sequence matches the write order exactly, and o_tx_free is consistent after each edge.
